// File: rtl/adi_jesd_tx_din_fifo.sv
// adi_jesd_tx_din_fifo: sync-aligned prefilled FIFO feeding the JESD TX transport; optional ramp source under JESD_TX_TESTPAT_EN
module adi_jesd_tx_din_fifo #(
  parameter int DEPTH = 64,
  parameter int PREFILL = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              link_clk,
  input  logic              link_rst,
  input  logic [511:0]      din,
  input  logic              din_vld,
  input  logic              din_sync,
  input  logic              tx_ready,
`ifdef JESD_TX_TESTPAT_EN
  input  logic              tp_en,
`endif
  input  logic              status_clr,
  output logic [511:0]      tx_data,
  output logic              tx_valid,
  output logic              din_overflow,
  output logic              tx_underflow,
  output logic [ADDR_W:0]   fifo_level,
  output logic [1:0]        state
);
  typedef enum logic [1:0] {ALIGN = 2'd0, FILL = 2'd1, RUN = 2'd2} state_t;
  localparam logic [ADDR_W:0] PRE = (ADDR_W + 1)'(PREFILL);
  state_t cur, nxt;
  logic [511:0] mem [DEPTH];
  logic [ADDR_W:0] wr_ptr, rd_ptr, level_nxt;
  logic empty, full, wr_req, wr_en, drop, pop, uf;
  assign fifo_level = wr_ptr - rd_ptr;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) && (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);
  assign state = cur;
  // an underflow flush swallows the same-cycle input, even a sync word
  always_comb begin
    uf = cur == RUN && tx_ready && empty;
    pop = cur == RUN && tx_ready && !empty;
    wr_req = din_vld && (cur == ALIGN ? din_sync : !uf);
    wr_en = wr_req && !full;
    drop = wr_req && full;
    level_nxt = fifo_level + {{ADDR_W{1'b0}}, wr_en};
    nxt = cur;
    case (cur)
      ALIGN: if (wr_en) nxt = FILL;
      FILL: if (level_nxt >= PRE) nxt = RUN;
      RUN: if (uf) nxt = ALIGN;
      default: nxt = ALIGN;
    endcase
  end
  always_ff @(posedge link_clk)
    if (wr_en) mem[wr_ptr[ADDR_W-1:0]] <= din;
  always_ff @(posedge link_clk) begin
    if (link_rst) begin
      cur <= ALIGN;
      wr_ptr <= '0;
      rd_ptr <= '0;
      din_overflow <= 1'b0;
      tx_underflow <= 1'b0;
    end else begin
      cur <= nxt;
      wr_ptr <= uf ? '0 : wr_ptr + {{ADDR_W{1'b0}}, wr_en};
      rd_ptr <= uf ? '0 : rd_ptr + {{ADDR_W{1'b0}}, pop};
      din_overflow <= drop | (din_overflow & ~status_clr);
      tx_underflow <= uf | (tx_underflow & ~status_clr);
    end
  end
`ifdef JESD_TX_TESTPAT_EN
  logic [15:0] base;
  logic [511:0] ramp;
  for (genvar k = 0; k < 32; k++) begin : g_ramp
    assign ramp[16*k +: 16] = base + 16'(k);
  end
  always_ff @(posedge link_clk) begin
    if (link_rst) base <= '0;
    else if (tp_en && tx_ready) base <= base + 16'd32;
  end
`endif
  always_ff @(posedge link_clk) begin
    if (link_rst) begin
      tx_data <= '0;
      tx_valid <= 1'b0;
    end
`ifdef JESD_TX_TESTPAT_EN
    else if (tp_en && tx_ready) begin
      tx_data <= ramp;
      tx_valid <= 1'b1;
    end
`endif
    else if (pop) begin
      tx_data <= mem[rd_ptr[ADDR_W-1:0]];
      tx_valid <= 1'b1;
    end else if (uf) begin
      tx_data <= '0;
      tx_valid <= 1'b0;
    end
  end
endmodule
